// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch / execute / memory / writeback control FSM
// for the RV32E core. Holds the instruction register, PC and retire counter,
// and halts (sticky) on ebreak or when a memory wait exceeds TIMEOUT cycles.
module instr_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] inst,
    input  logic        dec_regw,
    input  logic        dec_memwr,
    input  logic        dec_memtoreg,
    input  logic        dec_ebreak,
    input  logic [31:0] next_pc,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    input  logic        dmem_rsp_valid,
    output logic        rf_wen,
    output logic [31:0] pc,
    output logic        retire,
    output logic [31:0] instret,
    output logic        halt,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        BOOT, FETCH, IWAIT, EXEC, MEM, MWAIT, WB, HALT
    } state_t;

    // Last counter value allowed before a missing handshake becomes an error.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [15:0] wait_cnt;
    logic        at_limit;
    logic        to_hit;

    assign at_limit = (wait_cnt == WAIT_LAST);

    // Next-state logic; a handshake in the limit cycle takes priority over timeout.
    always_comb begin
        state_nxt = state;
        to_hit    = 1'b0;
        case (state)
            BOOT:  state_nxt = FETCH;
            FETCH: begin
                if (imem_req_ready)  state_nxt = IWAIT;
                else if (at_limit)   begin state_nxt = HALT; to_hit = 1'b1; end
            end
            IWAIT: begin
                if (imem_rsp_valid)  state_nxt = EXEC;
                else if (at_limit)   begin state_nxt = HALT; to_hit = 1'b1; end
            end
            EXEC: begin
                if (dec_ebreak)                     state_nxt = HALT;
                else if (dec_memwr || dec_memtoreg) state_nxt = MEM;
                else                                state_nxt = WB;
            end
            MEM: begin
                if (dmem_req_ready)  state_nxt = MWAIT;
                else if (at_limit)   begin state_nxt = HALT; to_hit = 1'b1; end
            end
            MWAIT: begin
                if (dmem_rsp_valid)  state_nxt = WB;
                else if (at_limit)   begin state_nxt = HALT; to_hit = 1'b1; end
            end
            WB:      state_nxt = FETCH;
            HALT:    state_nxt = HALT;
            default: state_nxt = BOOT;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= BOOT;
        else     state <= state_nxt;
    end

    // Wait counter: restarts on any state change, counts dwell in wait states.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wait_cnt <= '0;
        else if (state_nxt != state)
            wait_cnt <= '0;
        else if (state inside {FETCH, IWAIT, MEM, MWAIT})
            wait_cnt <= wait_cnt + 16'd1;
    end

    // Architectural state: instruction register, PC, retire count, sticky halt flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst        <= '0;
            pc          <= RESET_PC;
            instret     <= '0;
            halt        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (state == IWAIT && imem_rsp_valid) inst <= imem_rsp_data;
            if (state == WB) begin
                pc      <= next_pc;
                instret <= instret + 32'd1;
            end
            if (state_nxt == HALT) halt <= 1'b1;
            if (to_hit)            timeout_err <= 1'b1;
        end
    end

    assign imem_req_valid = (state == FETCH);
    assign imem_req_addr  = pc;
    assign dmem_req_valid = (state == MEM);
    assign retire         = (state == WB);
    // Decoder output is stable in WB since inst is held.
    assign rf_wen         = (state == WB) && dec_regw;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: addi stream, delayed store, jal,
// reset in a load wait, ebreak halt, and fetch timeout / last-cycle response.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] inst;
    logic        dec_regw, dec_memwr, dec_memtoreg, dec_ebreak;
    logic [31:0] next_pc;
    logic        dmem_req_valid, dmem_req_ready, dmem_rsp_valid;
    logic        rf_wen;
    logic [31:0] pc;
    logic        retire;
    logic [31:0] instret;
    logic        halt, timeout_err;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_pc;

    localparam logic [31:0] ADDI   = 32'h0010_0093;
    localparam logic [31:0] SW     = 32'h0011_2023;
    localparam logic [31:0] JAL    = 32'h0F00_00EF;
    localparam logic [31:0] LW     = 32'h0001_2083;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    instr_sequencer #(.RESET_PC(32'h8000_0000), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .inst(inst),
        .dec_regw(dec_regw), .dec_memwr(dec_memwr), .dec_memtoreg(dec_memtoreg),
        .dec_ebreak(dec_ebreak), .next_pc(next_pc),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_rsp_valid(dmem_rsp_valid), .rf_wen(rf_wen), .pc(pc),
        .retire(retire), .instret(instret), .halt(halt), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Hold reset for two edges, release just after an edge; FSM is then in BOOT.
    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Entered in FETCH with zero-wait memory: FETCH, IWAIT, EXEC, WB, back to FETCH.
    task automatic run_alu(input string tag, input logic [31:0] op, input logic [31:0] npc);
        imem_rsp_data = op;
        dec_regw = 1'b1; dec_memwr = 1'b0; dec_memtoreg = 1'b0; dec_ebreak = 1'b0;
        next_pc = npc;
        chk({tag, "_ivalid"}, imem_req_valid, 1);
        chk({tag, "_iaddr"}, imem_req_addr, exp_pc);
        step();                             // IWAIT
        step();                             // EXEC
        chk({tag, "_inst"}, inst, op);
        chk({tag, "_exec_retire"}, retire, 0);
        step();                             // WB
        chk({tag, "_retire"}, retire, 1);
        chk({tag, "_rfwen"}, rf_wen, 1);
        step();                             // FETCH
        exp_pc = npc;
        chk({tag, "_pc"}, pc, exp_pc);
    endtask

    initial begin
        rst = 1'b1;
        imem_req_ready = 1'b1; imem_rsp_valid = 1'b1; imem_rsp_data = '0;
        dec_regw = 1'b0; dec_memwr = 1'b0; dec_memtoreg = 1'b0; dec_ebreak = 1'b0;
        next_pc = '0;
        dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
        exp_pc = 32'h8000_0000;

        // Reset state
        step();
        chk("rst_pc", pc, 32'h8000_0000);
        chk("rst_inst", inst, 0);
        chk("rst_instret", instret, 0);
        chk("rst_halt", {halt, timeout_err}, 0);
        chk("rst_reqs", {imem_req_valid, dmem_req_valid, rf_wen, retire}, 0);
        step();
        rst = 1'b0;
        chk("boot_ivalid", imem_req_valid, 0);
        step();                             // FETCH: second cycle after release

        // Three addi
        for (int i = 0; i < 3; i++) run_alu("addi", ADDI, exp_pc + 32'd4);
        chk("addi_instret", instret, 3);
        chk("addi_pc", pc, 32'h8000_000C);

        // sw with dmem_req_ready delayed 3 cycles, response 2 cycles later
        imem_rsp_data = SW;
        dec_regw = 1'b0; dec_memwr = 1'b1; dec_memtoreg = 1'b0;
        next_pc = exp_pc + 32'd4;
        step(); step(); step();             // IWAIT, EXEC, MEM
        for (int i = 0; i < 3; i++) begin
            chk("sw_dvalid_hold", dmem_req_valid, 1);
            step();
        end
        dmem_req_ready = 1'b1;
        chk("sw_dvalid_last", dmem_req_valid, 1);
        step();                             // MWAIT
        dmem_req_ready = 1'b0;
        chk("sw_dvalid_drop", dmem_req_valid, 0);
        chk("sw_mwait_retire", retire, 0);
        step();
        dmem_rsp_valid = 1'b1;
        step();                             // WB
        dmem_rsp_valid = 1'b0;
        chk("sw_retire", retire, 1);
        chk("sw_rfwen", rf_wen, 0);
        step();                             // FETCH
        chk("sw_retire_once", retire, 0);
        chk("sw_pc", pc, 32'h8000_0010);
        chk("sw_instret", instret, 4);
        exp_pc = 32'h8000_0010;

        // jal to 8000_0100
        dec_memwr = 1'b0;
        run_alu("jal", JAL, 32'h8000_0100);
        chk("jal_iaddr", imem_req_addr, 32'h8000_0100);
        chk("jal_ivalid", imem_req_valid, 1);
        chk("jal_instret", instret, 5);

        // lw, reset asserted in MWAIT
        imem_rsp_data = LW;
        dec_regw = 1'b1; dec_memwr = 1'b0; dec_memtoreg = 1'b1;
        next_pc = 32'h8000_0104;
        dmem_req_ready = 1'b1;
        step(); step(); step();             // IWAIT, EXEC, MEM
        chk("lw_dvalid", dmem_req_valid, 1);
        step();                             // MWAIT
        dmem_req_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("lw_rst_dvalid", dmem_req_valid, 0);
        chk("lw_rst_retire", {retire, rf_wen, imem_req_valid}, 0);
        chk("lw_rst_pc", pc, 32'h8000_0000);
        chk("lw_rst_instret", instret, 0);
        chk("lw_rst_inst", inst, 0);
        dec_memtoreg = 1'b0;
        do_reset();
        step();                             // FETCH
        exp_pc = 32'h8000_0000;
        chk("refetch_addr", imem_req_addr, 32'h8000_0000);
        chk("refetch_instret", instret, 0);

        // Two addi, then ebreak at 8000_0008
        for (int i = 0; i < 2; i++) run_alu("addi2", ADDI, exp_pc + 32'd4);
        imem_rsp_data = EBREAK;
        dec_regw = 1'b0; dec_ebreak = 1'b1;
        next_pc = 32'h8000_000C;
        step(); step();                     // IWAIT, EXEC
        chk("ebrk_exec_halt", halt, 0);
        step();                             // HALT
        chk("ebrk_halt", halt, 1);
        chk("ebrk_toerr", timeout_err, 0);
        chk("ebrk_pc", pc, 32'h8000_0008);
        chk("ebrk_instret", instret, 2);
        chk("ebrk_retire", retire, 0);
        for (int i = 0; i < 20; i++) begin
            chk("halt_ivalid", imem_req_valid, 0);
            step();
        end
        chk("halt_sticky", halt, 1);
        dec_ebreak = 1'b0;

        // Fetch response never arrives: halt after 8 cycles in IWAIT
        imem_rsp_valid = 1'b0;
        exp_pc = 32'h8000_0000;
        do_reset();
        step();                             // FETCH
        step();                             // IWAIT cycle 1
        for (int i = 0; i < 7; i++) begin
            chk("to_wait_halt", halt, 0);
            step();
        end
        chk("to_last_halt", halt, 0);
        step();
        chk("to_halt", halt, 1);
        chk("to_err", timeout_err, 1);
        chk("to_instret", instret, 0);

        // Response in the 8th IWAIT cycle: normal retire
        do_reset();
        step();                             // FETCH
        chk("late_rst_err", timeout_err, 0);
        imem_rsp_data = ADDI;
        dec_regw = 1'b1;
        next_pc = 32'h8000_0004;
        step();                             // IWAIT cycle 1
        for (int i = 0; i < 7; i++) step();
        imem_rsp_valid = 1'b1;              // cycle 8
        step();                             // EXEC
        imem_rsp_valid = 1'b0;
        chk("late_halt", {halt, timeout_err}, 0);
        chk("late_inst", inst, ADDI);
        step();                             // WB
        chk("late_retire", retire, 1);
        step();
        chk("late_instret", instret, 1);
        chk("late_pc", pc, 32'h8000_0004);
        chk("late_noerr", {halt, timeout_err}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
